// File: rtl/pwm_duty_ramp_if.sv
`timescale 1ns/1ps
// pwm_duty_ramp_if
// Target-offer channel into the duty ramp scheduler.
//   tgt_valid : producer offers a new compare target
//   tgt_cmpa  : requested compare value (W bits)
//   tgt_ready : scheduler can accept; transfer happens on valid && ready
// master = target producer, slave = pwm_duty_ramp.
interface pwm_duty_ramp_if #(
    parameter int W = 10
);
    logic         tgt_valid;
    logic [W-1:0] tgt_cmpa;
    logic         tgt_ready;

    modport master (output tgt_valid, output tgt_cmpa, input tgt_ready);
    modport slave  (input tgt_valid, input tgt_cmpa, output tgt_ready);
endinterface

// File: rtl/pwm_duty_ramp.sv
`timescale 1ns/1ps
// pwm_duty_ramp
// Drives the CMPA compare value of a PWM generator. Accepted targets are
// approached in steps of at most KSTEP, one step every KSTEP_PERIODS PWM
// periods, and CMPA only moves at a period boundary (or on shutdown).
// A private prescaler/period counter pair mirrors the PWM timebase.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   enable     : low forces shutdown (CMPA=0, target discarded)
//   tgt        : target offer channel (slave side)
//   CMPA       : compare value to the PWM
//   period_end : one-cycle strobe on the last clk of each PWM period
//   busy       : ramp in progress
//   at_target  : CMPA equals the accepted target (HOLD)
module pwm_duty_ramp #(
    parameter int KPERIOD       = 1000,
    parameter int KCLKDIV       = 10,
    parameter int KSTEP         = 10,
    parameter int KSTEP_PERIODS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    pwm_duty_ramp_if.slave             tgt,
    output logic [$clog2(KPERIOD)-1:0] CMPA,
    output logic                       period_end,
    output logic                       busy,
    output logic                       at_target
);
    localparam int W       = $clog2(KPERIOD);
    localparam int PW      = (KCLKDIV > 1) ? $clog2(KCLKDIV) : 1;
    localparam int SW      = (KSTEP_PERIODS > 1) ? $clog2(KSTEP_PERIODS) : 1;
    // A step larger than the full range can never be used.
    localparam int KSTEP_C = (KSTEP < KPERIOD) ? KSTEP : KPERIOD;

    localparam logic [W-1:0]  CMPA_MAX  = W'(KPERIOD - 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(KCLKDIV - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(KSTEP_PERIODS - 1);
    localparam logic [W:0]    STEP_MAX  = (W + 1)'(KSTEP_C);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_HOLD = 2'd1,
        ST_RAMP = 2'd2
    } state_t;

    state_t         state_q;
    logic [PW-1:0]  presc_q, presc_d;
    logic [W-1:0]   per_q, per_d;
    logic           period_end_q, period_end_d;
    logic [SW-1:0]  step_q;
    logic [W-1:0]   cmpa_q;
    logic [W-1:0]   target_q;

    logic [W-1:0]   tgt_clamp_s;
    logic [W:0]     diff_s;
    logic [W:0]     mag_s;
    logic [W-1:0]   step_s;
    logic [W-1:0]   cmpa_step_s;

    // Timebase next state; counters are held at zero while disabled or OFF so
    // that the first period starts on the clk that enters HOLD.
    always_comb begin
        presc_d = presc_q;
        per_d   = per_q;
        if (!enable || (state_q == ST_OFF)) begin
            presc_d = '0;
            per_d   = '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (per_q == CMPA_MAX) begin
                per_d = '0;
            end else begin
                per_d = per_q + W'(1);
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
        // Decoded from the next counter values so the registered strobe lines
        // up with the last clk of the period rather than trailing it.
        period_end_d = (presc_d == PRESC_MAX) && (per_d == CMPA_MAX);
    end

    // Target clamp and bounded step toward the target; the W+1 bit difference
    // carries the direction in its MSB so the step can never overshoot.
    always_comb begin
        if (tgt.tgt_cmpa > CMPA_MAX) begin
            tgt_clamp_s = CMPA_MAX;
        end else begin
            tgt_clamp_s = tgt.tgt_cmpa;
        end
        diff_s = {1'b0, target_q} - {1'b0, cmpa_q};
        if (diff_s[W]) begin
            mag_s = {(W + 1){1'b0}} - diff_s;
        end else begin
            mag_s = diff_s;
        end
        if (mag_s > STEP_MAX) begin
            step_s = STEP_MAX[W-1:0];
        end else begin
            step_s = mag_s[W-1:0];
        end
        if (diff_s[W]) begin
            cmpa_step_s = cmpa_q - step_s;
        end else begin
            cmpa_step_s = cmpa_q + step_s;
        end
    end

    // Scheduler FSM with timebase, compare and target registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_OFF;
            presc_q      <= '0;
            per_q        <= '0;
            period_end_q <= 1'b0;
            step_q       <= '0;
            cmpa_q       <= '0;
            target_q     <= '0;
        end else begin
            presc_q      <= presc_d;
            per_q        <= per_d;
            period_end_q <= period_end_d;
            if (!enable) begin
                state_q  <= ST_OFF;
                step_q   <= '0;
                cmpa_q   <= '0;
                target_q <= '0;
            end else begin
                case (state_q)
                    ST_OFF: begin
                        state_q  <= ST_HOLD;
                        step_q   <= '0;
                        cmpa_q   <= '0;
                        target_q <= '0;
                    end
                    ST_HOLD: begin
                        if (tgt.tgt_valid) begin
                            target_q <= tgt_clamp_s;
                            step_q   <= '0;
                            if (tgt_clamp_s != cmpa_q) begin
                                state_q <= ST_RAMP;
                            end
                        end
                    end
                    ST_RAMP: begin
                        if (period_end_q) begin
                            if (step_q == STEP_LAST) begin
                                cmpa_q <= cmpa_step_s;
                                step_q <= '0;
                                if (cmpa_step_s == target_q) begin
                                    state_q <= ST_HOLD;
                                end
                            end else begin
                                step_q <= step_q + SW'(1);
                            end
                        end
                    end
                    default: begin
                        state_q  <= ST_OFF;
                        step_q   <= '0;
                        cmpa_q   <= '0;
                        target_q <= '0;
                    end
                endcase
            end
        end
    end

    assign CMPA          = cmpa_q;
    assign period_end    = period_end_q;
    assign tgt.tgt_ready = (state_q == ST_HOLD);
    assign busy          = (state_q == ST_RAMP);
    assign at_target     = (state_q == ST_HOLD);

endmodule
